// File: rtl/task1_cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: one IR load plus one
// DR_WIDTH-bit data scan per command, with tck generated from clk.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a command, tck low, rti strobe high
// UIR    | one tck period presenting vji_ir_in, samples vji_ir_out at rise
// CDR    | one tck period of capture-DR
// SDR    | DR_WIDTH tck periods shifting sr out on tdi and tdo into sr
// E1DR   | one tck period of exit1-DR, tdi low
// DONE   | response held on rsp_* until rsp_ready
module task1_cpu_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_e1dr
);

    localparam int DIV_W = $clog2(2 * TCK_DIV);
    localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(TCK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_E1DR = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]          state;
    logic [DIV_W-1:0]    div;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DR_WIDTH-1:0] sr;
    logic                tdo_q;

    // Strobes decode straight from state, so they are one-hot by construction
    // and only move when state does (entry or a fall event).
    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign rsp_dr    = sr;
    assign vji_rti   = (state == S_IDLE) || (state == S_DONE);
    assign vji_uir   = (state == S_UIR);
    assign vji_cdr   = (state == S_CDR);
    assign vji_sdr   = (state == S_SDR);
    assign vji_e1dr  = (state == S_E1DR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            tdo_q     <= 1'b0;
            rsp_ir    <= '0;
            vji_tck   <= 1'b0;
            vji_tdi   <= 1'b0;
            vji_ir_in <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state     <= S_UIR;
                        sr        <= cmd_dr;
                        vji_ir_in <= cmd_ir;
                        div       <= DIV_TOP;
                        bit_cnt   <= '0;
                        vji_tck   <= 1'b0;
                        vji_tdi   <= 1'b0;
                    end
                end
                S_UIR, S_CDR, S_SDR, S_E1DR: begin
                    // div counts down through one tck period; zero is the fall event
                    if (div == '0) begin
                        vji_tck <= 1'b0;
                        div     <= DIV_TOP;
                        if (state == S_UIR) begin
                            state <= S_CDR;
                        end else if (state == S_CDR) begin
                            state   <= S_SDR;
                            vji_tdi <= sr[0];
                        end else if (state == S_SDR) begin
                            sr <= {tdo_q, sr[DR_WIDTH-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                state   <= S_E1DR;
                                vji_tdi <= 1'b0;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                vji_tdi <= sr[1];
                            end
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        div <= div - 1'b1;
                        if (div == DIV_MID) begin
                            vji_tck <= 1'b1;
                            if (state == S_UIR) rsp_ir <= vji_ir_out;
                            if (state == S_SDR) tdo_q  <= vji_tdo;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_task1_cpu_debug_scan_master.sv
// Self-checking bench for task1_cpu_debug_scan_master: a behavioural debug-slave
// model on the vji_* nets plus a table of commands with expected responses.
module tb_task1_cpu_debug_scan_master;

    localparam int DW = 38;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // DUT A, default divider
    logic          cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [IW-1:0] cmd_ir = '0, ir_out = '0;
    logic [DW-1:0] cmd_dr = '0;
    logic          cmd_ready, rsp_valid, tck, tdi, tdo, rti, uir, cdr, sdr, e1dr;
    logic [DW-1:0] rsp_dr;
    logic [IW-1:0] rsp_ir, ir_in;

    task1_cpu_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir(rsp_ir),
        .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in), .vji_ir_out(ir_out),
        .vji_rti(rti), .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_e1dr(e1dr));

    // DUT B, TCK_DIV=1
    logic          cmd_valid_b = 1'b0, rsp_ready_b = 1'b0;
    logic [IW-1:0] cmd_ir_b = '0, ir_out_b = 2'b01;
    logic [DW-1:0] cmd_dr_b = '0;
    logic          cmd_ready_b, rsp_valid_b, tck_b, tdi_b, tdo_b;
    logic          rti_b, uir_b, cdr_b, sdr_b, e1dr_b;
    logic [DW-1:0] rsp_dr_b;
    logic [IW-1:0] rsp_ir_b, ir_in_b;

    task1_cpu_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_dr(rsp_dr_b), .rsp_ir(rsp_ir_b),
        .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_in_b), .vji_ir_out(ir_out_b),
        .vji_rti(rti_b), .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_e1dr(e1dr_b));

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Debug-slave model for A: drives pat bit k during the k-th shift, or echoes
    // the tdi seen at the previous tck rise in loopback mode.
    logic [DW-1:0] pat = '0;
    logic [DW-1:0] rx = '0;
    logic          loop_mode = 1'b0;
    logic          prev_tdi = 1'b0;
    logic [5:0]    rise_cnt = '0;
    logic [2:0]    seq_arr [0:63];
    logic [6:0]    seq_n = '0;

    function automatic logic [2:0] strobe_code(input logic u, input logic c, input logic s, input logic e);
        return u ? 3'd1 : c ? 3'd2 : s ? 3'd3 : e ? 3'd4 : 3'd0;
    endfunction

    assign tdo = loop_mode ? prev_tdi : ((rise_cnt < 6'd38) ? pat[rise_cnt] : 1'b0);

    always @(posedge tck) begin
        prev_tdi <= tdi;
        if (uir) begin
            rise_cnt   <= '0;
            seq_arr[0] <= 3'd1;
            seq_n      <= 7'd1;
        end else begin
            if (sdr && rise_cnt < 6'd38) begin
                rx[rise_cnt] <= tdi;
                rise_cnt     <= rise_cnt + 6'd1;
            end
            if (seq_n < 7'd64) begin
                seq_arr[seq_n[5:0]] <= strobe_code(uir, cdr, sdr, e1dr);
                seq_n               <= seq_n + 7'd1;
            end
        end
    end

    // Slave model for B plus tck-toggle and one-hot monitors
    logic [DW-1:0] pat_b = '0;
    logic [5:0]    cnt_b = '0;
    assign tdo_b = (cnt_b < 6'd38) ? pat_b[cnt_b] : 1'b0;
    always @(posedge tck_b) begin
        if (uir_b) cnt_b <= '0;
        else if (sdr_b && cnt_b < 6'd38) cnt_b <= cnt_b + 6'd1;
    end

    logic act_b;
    logic prev_act_b = 1'b0, prev_tck_b = 1'b0;
    int   tog_err = 0, oh_err = 0, oh_err_b = 0;
    assign act_b = uir_b | cdr_b | sdr_b | e1dr_b;
    always @(negedge clk) begin
        if (act_b && prev_act_b && tck_b == prev_tck_b) tog_err <= tog_err + 1;
        prev_act_b <= act_b;
        prev_tck_b <= tck_b;
        if ($countones({rti, uir, cdr, sdr, e1dr}) != 1) oh_err <= oh_err + 1;
        if ($countones({rti_b, uir_b, cdr_b, sdr_b, e1dr_b}) != 1) oh_err_b <= oh_err_b + 1;
    end

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_dr"}, rsp_dr, 0);
        check({tag, "_rsp_ir"}, rsp_ir, 0);
        check({tag, "_tck"}, tck, 0);
        check({tag, "_tdi"}, tdi, 0);
        check({tag, "_ir_in"}, ir_in, 0);
        check({tag, "_rti"}, rti, 1);
        check({tag, "_strobes"}, {uir, cdr, sdr, e1dr}, 0);
    endtask

    // Offer a command and wait for the response; lat is the edge number (accept
    // edge = 0) whose sample first sees rsp_valid.
    task automatic run_cmd(input logic [IW-1:0] ir, input logic [DW-1:0] dr, output int lat);
        int n;
        int m;
        @(negedge clk);
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ir_in_latched", ir_in, ir);
        m = 0;
        while (!rsp_valid && m < 2000) begin @(negedge clk); m++; end
        lat = m + 1;
    endtask

    task automatic take_rsp();
        @(negedge clk) rsp_ready = 1'b1;
        @(negedge clk) rsp_ready = 1'b0;
        check("cmd_ready_after_take", cmd_ready, 1);
        check("rsp_valid_cleared", rsp_valid, 0);
    endtask

    task automatic check_seq(input string tag);
        logic ok;
        ok = (seq_n == 7'd41) && (seq_arr[0] == 3'd1) && (seq_arr[1] == 3'd2) && (seq_arr[40] == 3'd4);
        for (int k = 2; k < 40; k++) if (seq_arr[k] != 3'd3) ok = 1'b0;
        check({tag, "_strobe_order"}, ok, 1);
    endtask

    typedef struct {
        logic [IW-1:0] ir;
        logic [DW-1:0] dr;
        logic [DW-1:0] pat;
        logic [IW-1:0] ir_out;
        logic          loopback;
        logic [DW-1:0] exp_rsp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int            lat;
        int            bp_err;
        int            stray;
        int            k;
        int            m;
        logic [63:0]   r;
        logic [DW-1:0] held, dr2;
        string         tag;

        vecs[0] = '{ir: 2'b10, dr: 38'h2A_AAAA_AAAA, pat: 38'h15_5555_5555, ir_out: 2'b01, loopback: 1'b0, exp_rsp: '0};
        vecs[1] = '{ir: 2'b01, dr: 38'h00_0000_0001, pat: '0, ir_out: 2'b10, loopback: 1'b1, exp_rsp: '0};
        vecs[2] = '{ir: 2'b11, dr: 38'h3F_FFFF_FFFF, pat: 38'h00_0000_0000, ir_out: 2'b11, loopback: 1'b0, exp_rsp: '0};
        for (int i = 3; i < 8; i++) begin
            r = {$urandom(), $urandom()};
            vecs[i].dr = r[DW-1:0];
            r = {$urandom(), $urandom()};
            vecs[i].pat = r[DW-1:0];
            vecs[i].ir = IW'($urandom_range(0, 3));
            vecs[i].ir_out = IW'($urandom_range(0, 3));
            vecs[i].loopback = (i == 5);
        end
        // A loopback slave returns each bit one period late: the data shifted left by one.
        for (int i = 0; i < 8; i++)
            vecs[i].exp_rsp = vecs[i].loopback ? {vecs[i].dr[DW-2:0], 1'b0} : vecs[i].pat;

        #2 reset = 1'b1;
        #1 check_reset("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("v%0d", i);
            pat = vecs[i].pat; loop_mode = vecs[i].loopback; ir_out = vecs[i].ir_out;
            run_cmd(vecs[i].ir, vecs[i].dr, lat);
            check({tag, "_latency"}, lat, 329);
            check({tag, "_rsp_dr"}, rsp_dr, vecs[i].exp_rsp);
            check({tag, "_slave_rx"}, rx, vecs[i].dr);
            check({tag, "_rsp_ir"}, rsp_ir, vecs[i].ir_out);
            check({tag, "_done_strobes"}, {rti, uir, cdr, sdr, e1dr, tck}, 6'b100000);
            check_seq(tag);
            take_rsp();
        end

        // Backpressure with a second command already waiting
        pat = vecs[0].pat; loop_mode = 1'b0; ir_out = 2'b11;
        run_cmd(2'b01, vecs[0].dr, lat);
        check("bp_first_latency", lat, 329);
        held = rsp_dr;
        dr2 = 38'h12_3456_789A;
        cmd_ir = 2'b10; cmd_dr = dr2; cmd_valid = 1'b1;
        bp_err = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_dr !== held) bp_err++;
        end
        check("bp_hold", bp_err, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_ready_at_n1", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_accept_at_n1", {uir, cmd_ready}, 2'b10);
        check("bp_ir_in", ir_in, 2'b10);
        m = 0;
        while (!rsp_valid && m < 2000) begin @(negedge clk); m++; end
        check("bp_second_latency", m + 1, 329);
        check("bp_second_rsp_dr", rsp_dr, pat);
        check("bp_second_rx", rx, dr2);
        take_rsp();

        // Reset in the middle of bit 17 of the data scan
        pat = vecs[4].pat; loop_mode = 1'b0;
        @(negedge clk);
        cmd_ir = 2'b11; cmd_dr = vecs[3].dr; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!(sdr && rise_cnt == 6'd17) && k < 1000) begin @(negedge clk); k++; end
        check("reached_bit17", (k < 1000), 1);
        #2 reset = 1'b1;
        #1 check_reset("mid_sdr");
        @(negedge clk) reset = 1'b0;
        stray = 0;
        repeat (12) begin @(negedge clk); if (rsp_valid) stray++; end
        check("no_rsp_after_abort", stray, 0);
        run_cmd(2'b01, vecs[6].dr, lat);
        check("post_reset_latency", lat, 329);
        check("post_reset_rsp_dr", rsp_dr, pat);
        check("post_reset_rx", rx, vecs[6].dr);
        take_rsp();

        // TCK_DIV=1 instance with the fixed pattern
        @(negedge clk);
        pat_b = vecs[0].pat; cmd_dr_b = vecs[0].dr; cmd_ir_b = 2'b10; cmd_valid_b = 1'b1;
        check("b_cmd_ready", cmd_ready_b, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid_b = 1'b0;
        m = 0;
        while (!rsp_valid_b && m < 500) begin @(negedge clk); m++; end
        check("b_latency", m + 1, 83);
        check("b_rsp_dr", rsp_dr_b, vecs[0].pat);
        check("b_rsp_ir", rsp_ir_b, ir_out_b);
        check("b_tck_toggle", tog_err, 0);
        @(negedge clk) rsp_ready_b = 1'b1;
        @(negedge clk) rsp_ready_b = 1'b0;
        check("b_cmd_ready_after_take", cmd_ready_b, 1);

        check("onehot_a", oh_err, 0);
        check("onehot_b", oh_err_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/task1_cpu_debug_scan_master.md
# task1_cpu_debug_scan_master

Host-side initiator for the Nios II debug slave's virtual-JTAG link. It accepts one command at a time: a 2-bit instruction and a 38-bit data word. For each command it generates tck, the virtual state strobes, ir_in and tdi exactly as the virtual-JTAG hub presents them to the debug slave, and returns the 38 bits shifted out on tdo. It sits between a bench or on-chip debug host and the debug slave wrapper's vji_* nets, replacing the sld hub in simulation and hub-less builds.

## Interface
Parameters:
- DR_WIDTH, 38, data-register scan length in bits.
- IR_WIDTH, 2, virtual instruction width.
- TCK_DIV, 4, clk cycles per tck half-period (≥1); one tck period is 2·TCK_DIV clk.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_dr  in  DR_WIDTH  data to shift in, LSB first.
- rsp_valid  out  1  result available; held until taken.
- rsp_ready  in  1  host accepts the result.
- rsp_dr  out  DR_WIDTH  captured tdo bits; bit 0 is the first bit out.
- rsp_ir  out  IR_WIDTH  vji_ir_out sampled during UIR.
- vji_tck  out  1  generated tck.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  instruction presented to the slave.
- vji_ir_out  in  IR_WIDTH  slave status.
- vji_rti, vji_uir, vji_cdr, vji_sdr, vji_e1dr  out  1 each  virtual state strobes.

## Operation
- States: IDLE → UIR → CDR → SDR → E1DR → DONE → IDLE.
- IDLE
  - cmd_ready=1, vji_rti=1, tck held low.
  - On cmd_valid&&cmd_ready, latch cmd_ir and load the shift register sr ← cmd_dr.
- Per tck period: a low phase of TCK_DIV clk, then a high phase of TCK_DIV clk.
  - Rise event: the clk edge where tck goes 1.
  - Fall event: the clk edge where tck returns to 0, which ends the period.
- UIR (1 period)
  - vji_ir_in ← latched instruction at entry; vji_ir_in then holds until the next command's UIR.
  - vji_uir=1.
  - At the rise event, rsp_ir ← vji_ir_out.
- CDR (1 period): vji_cdr=1.
- SDR (exactly DR_WIDTH periods)
  - vji_sdr=1; vji_tdi=sr[0], which is registered.
  - At the rise event, tdo_q ← vji_tdo.
  - At the fall event, sr ← {tdo_q, sr[DR_WIDTH-1:1]}.
  - A bit counter runs 0..DR_WIDTH-1 and exits SDR at the fall event of the last bit.
- E1DR (1 period): vji_e1dr=1; tdi=0.
- DONE
  - rsp_valid=1, rsp_dr=sr, tck low; all strobes 0 except vji_rti=1.
  - Leave on rsp_valid&&rsp_ready.
- Strobes:
  - Change only at fall events or at state entry.
  - Exactly one of rti/uir/cdr/sdr/e1dr is high at any time.
- Boundaries:
  - cmd_valid while busy is ignored; the command is not lost, because the host holds it.
  - rsp_dr/rsp_ir are stable while rsp_valid=1.
  - TCK_DIV=1 gives tck = clk/2.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - vji_rti=1; uir/cdr/sdr/e1dr=0; divider and bit counter 0.
- Reset mid-scan aborts with no response; the next command starts clean.
- Accept at edge 0 → UIR entered on edge 1 with tck=0.
- rsp_valid rises on edge 1 + (DR_WIDTH+3)·2·TCK_DIV; the defaults give 329.
- Response handshake at edge n → cmd_ready=1 from edge n+1. A new command can be accepted at n+1 at the earliest.
- tdi is stable for TCK_DIV clk before and after every rise event.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle → all outputs take the reset values listed above within the same cycle.
- **Fixed tdo pattern:** bench model shifts 38'h15_5555_5555 out on tdo; cmd_ir=2'b10, cmd_dr=38'h2A_AAAA_AAAA → rsp_dr=38'h15_5555_5555 at edge 329. Model receives 38'h2A_AAAA_AAAA. Strobes appear in order uir, cdr, 38×sdr, e1dr. rsp_ir equals the model's ir_out.
- **Loopback:** vji_tdo wired to the previous-period tdi through a 1-bit register model; cmd_dr=38'h00_0000_0001 → rsp_dr=38'h00_0000_0002.
- **Backpressure:** rsp_ready held low for 20 cycles with cmd_valid held high → cmd_ready=0 and rsp_dr stable throughout. After the handshake, the second command is accepted exactly one cycle later.
- **Reset during SDR:** assert reset during bit 17 → immediate return to IDLE with no rsp_valid. The following command completes with the correct data.
- **TCK_DIV=1:** run the fixed-pattern scan → rsp_valid at edge 83; tck toggles every clk.
